// File: rtl/des_round_counter.sv
// Round sequencer for an iterative DES core: steps the round select for the
// datapath and key schedule, then captures the final-permutation output.
module des_round_counter #(
  parameter int DATA_W = 64,
  parameter int ROUNDS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  output logic [3:0]        count,
  output logic              finish,
  input  logic [DATA_W-1:0] i_Data,
  output logic [DATA_W-1:0] o_Data
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [3:0]          count_reg, count_next;
  logic                finish_reg, finish_next;
  logic [DATA_W-1:0]   data_reg, data_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      count_reg  <= 4'd0;
      finish_reg <= 1'b0;
      data_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      finish_reg <= finish_next;
      data_reg   <= data_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    finish_next = 1'b0;
    data_next   = data_reg;
    case (state_reg)
      IDLE: begin
        // Round 1 is registered on the start edge, so the count jumps to 1.
        if (init) begin
          state_next = RUN;
          count_next = 4'd1;
        end
      end
      RUN: begin
        if (count_reg >= LAST_ROUND) begin
          state_next  = IDLE;
          count_next  = 4'd0;
          finish_next = 1'b1;
          data_next   = i_Data;
        end else begin
          count_next = count_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  assign count  = count_reg;
  assign finish = finish_reg;
  assign o_Data = data_reg;

endmodule

// File: tb/tb_des_round_counter.sv
// Table-driven, scoreboarded bench for des_round_counter: vectors are queued
// as they are driven and popped for comparison one clock edge later.
module tb_des_round_counter;

  logic        clk;
  logic        reset;
  logic        init;
  logic [3:0]  count;
  logic        finish;
  logic [63:0] i_Data;
  logic [63:0] o_Data;

  des_round_counter #(.DATA_W(64), .ROUNDS(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .init   (init),
    .count  (count),
    .finish (finish),
    .i_Data (i_Data),
    .o_Data (o_Data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ini;
    logic [63:0] din;
    logic [3:0]  cnt;
    logic        fin;
    logic [63:0] dout;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   row_num   = 0;
  logic [63:0] prev_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic void add(input logic ini, input logic [63:0] din,
                              input logic [3:0] cnt, input logic fin,
                              input logic [63:0] dout);
    vec_t v;
    v.ini = ini; v.din = din; v.cnt = cnt; v.fin = fin; v.dout = dout;
    tbl.push_back(v);
  endfunction

  // One operation started from IDLE; init is re-asserted on the edge whose
  // pre-edge count equals init_at (0 = never), which must be ignored.
  function automatic void build_op(input logic [63:0] d_run, input logic [63:0] d_last,
                                   input logic [63:0] prev, input int init_at);
    add(1'b1, d_run, 4'd1, 1'b0, prev);
    for (int c = 2; c <= 15; c++)
      add((c - 1) == init_at, d_run, 4'(c), 1'b0, prev);
    add(1'b0, d_last, 4'd0, 1'b1, d_last);
    add(1'b0, d_run, 4'd0, 1'b0, d_last);
  endfunction

  task automatic run_table(input string name);
    vec_t exp;
    for (int i = 0; i < tbl.size(); i++) begin
      init   = tbl[i].ini;
      i_Data = tbl[i].din;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      check({name, ".count"},  {60'd0, count}, {60'd0, exp.cnt});
      check({name, ".finish"}, {63'd0, finish}, {63'd0, exp.fin});
      check({name, ".o_Data"}, o_Data, exp.dout);
      $display("%s row %0d: init=%b din=%h count=%0d finish=%b o_Data=%h",
               name, row_num, tbl[i].ini, tbl[i].din, count, finish, o_Data);
      row_num++;
    end
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    init   = 1'b0;
    i_Data = 64'd0;

    // Asynchronous reset, checked before any clock edge.
    #2 reset = 1'b0;
    #1;
    check("reset.count",  {60'd0, count}, 64'd0);
    check("reset.finish", {63'd0, finish}, 64'd0);
    check("reset.o_Data", o_Data, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) add(1'b0, 64'h0, 4'd0, 1'b0, 64'd0);
    run_table("idle");

    // Single operation, data held.
    build_op(64'h85E813540F0AB405, 64'h85E813540F0AB405, 64'd0, 0);
    run_table("single");

    // Capture only on the completion edge; o_Data holds its old value meanwhile.
    build_op(64'h1111, 64'hAAAA, 64'h85E813540F0AB405, 0);
    run_table("capture");

    // init re-asserted at count 7 must not disturb the run.
    build_op(64'h2222, 64'h5A5A_0000_0000_0007, 64'hAAAA, 7);
    run_table("init_ignored");

    // Back-to-back: init held high for three operations.
    prev_out = 64'h5A5A_0000_0000_0007;
    for (int k = 0; k < 48; k++) begin
      int          c;
      logic [63:0] d;
      c = (k + 1) % 16;
      d = 64'hB0000 + 64'(k);
      if (c == 0) prev_out = d;
      add(1'b1, d, 4'(c), c == 0, prev_out);
    end
    add(1'b0, 64'h0, 4'd0, 1'b0, prev_out);
    run_table("b2b");

    // Reset in the middle of a run, at count 9.
    add(1'b1, 64'h3333, 4'd1, 1'b0, prev_out);
    for (int c = 2; c <= 9; c++) add(1'b0, 64'h3333, 4'(c), 1'b0, prev_out);
    run_table("prerst");
    #2 reset = 1'b0;
    #1;
    check("midrst.count",  {60'd0, count}, 64'd0);
    check("midrst.finish", {63'd0, finish}, 64'd0);
    check("midrst.o_Data", o_Data, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) add(1'b0, {$urandom, $urandom}, 4'd0, 1'b0, 64'd0);
    run_table("postrst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
